calculator_input_ctrl: RTL and testbench

CALCULATOR_INPUT_CTRL -- requirements
Module: calculator_input_ctrl

---
 rtl/calculator_input_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_calculator_input_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calculator_input_ctrl.sv
// Calculator front panel controller.
// Turns five debounced button levels into cursor moves over a 6x4 key grid.
// Enter on the current key drives a small operand-entry state machine.
// All outputs come straight from registers.
module calculator_input_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_enter,
  output logic [2:0]  pos_x,
  output logic [1:0]  pos_y,
  output logic        mode,
  output logic [2:0]  op,
  output logic [15:0] op1,
  output logic [15:0] op2,
  output logic [15:0] input_screen,
  output logic        exec_pulse
);

  typedef enum logic [1:0] {
    S_OP1  = 2'd0,
    S_OP2  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int B_UP    = 0;
  localparam int B_DOWN  = 1;
  localparam int B_LEFT  = 2;
  localparam int B_RIGHT = 3;
  localparam int B_ENTER = 4;

  logic [4:0] btn_raw;
  logic [4:0] sync1;
  logic [4:0] sync2;
  logic [4:0] prev;
  logic [4:0] armed;
  logic [1:0] warm;
  logic [4:0] press;

  state_t      state;
  state_t      state_next;
  logic [2:0]  count;
  logic [2:0]  count_next;
  logic [2:0]  pos_x_next;
  logic [1:0]  pos_y_next;
  logic        mode_next;
  logic [2:0]  op_next;
  logic [15:0] op1_next;
  logic [15:0] op2_next;
  logic [15:0] screen_next;
  logic        exec_next;

  logic [3:0] key_digit;
  logic       enter_press;
  logic       is_digit;
  logic       is_op;
  logic       is_clr;
  logic       is_back;
  logic       is_mode;
  logic       is_exe;
  logic       digit_ok;

  assign btn_raw = {btn_enter, btn_right, btn_left, btn_down, btn_up};

  // Two-flop synchronizer plus edge history. The warm-up bits mark when sync2
  // holds a real sample after reset. A button is only armed once it has
  // genuinely been seen low, so a key held through reset release never fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      armed <= '0;
      warm  <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      prev  <= sync2;
      warm  <= {warm[0], 1'b1};
      armed <= armed | ({5{warm[1]}} & ~sync2);
    end
  end

  assign press = sync2 & ~prev & armed;

  // Key decode always uses the cursor position held before this cycle's move.
  assign key_digit   = {pos_y, pos_x[1:0]};
  assign enter_press = press[B_ENTER];
  assign is_digit    = enter_press && (pos_x < 3'd4);
  assign is_op       = enter_press && (pos_x == 3'd4);
  assign is_clr      = enter_press && (pos_x == 3'd5) && (pos_y == 2'd0);
  assign is_back     = enter_press && (pos_x == 3'd5) && (pos_y == 2'd1);
  assign is_mode     = enter_press && (pos_x == 3'd5) && (pos_y == 2'd2);
  assign is_exe      = enter_press && (pos_x == 3'd5) && (pos_y == 2'd3);
  assign digit_ok    = mode || (key_digit <= 4'd9);

  // Cursor movement: at most one move per cycle, up > down > left > right, with wrap.
  always_comb begin
    pos_x_next = pos_x;
    pos_y_next = pos_y;
    if (press[B_UP]) begin
      pos_y_next = (pos_y == 2'd0) ? 2'd3 : pos_y - 2'd1;
    end else if (press[B_DOWN]) begin
      pos_y_next = (pos_y == 2'd3) ? 2'd0 : pos_y + 2'd1;
    end else if (press[B_LEFT]) begin
      pos_x_next = (pos_x == 3'd0) ? 3'd5 : pos_x - 3'd1;
    end else if (press[B_RIGHT]) begin
      pos_x_next = (pos_x == 3'd5) ? 3'd0 : pos_x + 3'd1;
    end
  end

  // Entry state machine: next state and next operand/screen values for the decoded key.
  always_comb begin
    state_next  = state;
    mode_next   = mode;
    op_next     = op;
    op1_next    = op1;
    op2_next    = op2;
    screen_next = input_screen;
    count_next  = count;
    exec_next   = 1'b0;

    if (is_clr || is_mode) begin
      mode_next   = mode ^ is_mode;
      op_next     = 3'd0;
      op1_next    = 16'h0000;
      op2_next    = 16'h0000;
      screen_next = 16'h0000;
      count_next  = 3'd0;
      state_next  = S_OP1;
    end else begin
      case (state)
        S_OP1, S_OP2: begin
          if (is_digit) begin
            if (digit_ok && (count != 3'd4)) begin
              screen_next = {input_screen[11:0], key_digit};
              count_next  = count + 3'd1;
            end
          end else if (is_back) begin
            if (count != 3'd0) begin
              screen_next = input_screen >> 4;
              count_next  = count - 3'd1;
            end
          end else if (is_op) begin
            if (state == S_OP1) begin
              op1_next    = input_screen;
              op_next     = {1'b0, pos_y};
              screen_next = 16'h0000;
              count_next  = 3'd0;
              state_next  = S_OP2;
            end
          end else if (is_exe) begin
            if (state == S_OP2) begin
              op2_next   = input_screen;
              exec_next  = 1'b1;
              state_next = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (is_digit && digit_ok) begin
            op_next     = 3'd0;
            op1_next    = 16'h0000;
            op2_next    = 16'h0000;
            screen_next = {12'h000, key_digit};
            count_next  = 3'd1;
            state_next  = S_OP1;
          end
        end
        default: begin
          state_next = S_OP1;
        end
      endcase
    end
  end

  // State, cursor and datapath registers; every output is driven from here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_OP1;
      pos_x        <= 3'd0;
      pos_y        <= 2'd0;
      mode         <= 1'b0;
      op           <= 3'd0;
      op1          <= 16'h0000;
      op2          <= 16'h0000;
      input_screen <= 16'h0000;
      count        <= 3'd0;
      exec_pulse   <= 1'b0;
    end else begin
      state        <= state_next;
      pos_x        <= pos_x_next;
      pos_y        <= pos_y_next;
      mode         <= mode_next;
      op           <= op_next;
      op1          <= op1_next;
      op2          <= op2_next;
      input_screen <= screen_next;
      count        <= count_next;
      exec_pulse   <= exec_next;
    end
  end

endmodule

// File: tb/tb_calculator_input_ctrl.sv
// Testbench for calculator_input_ctrl.
// Directed scenarios and random button traffic are checked against a keypad model.
// The model keeps the entered digits as a queue.
module tb_calculator_input_ctrl;

  localparam logic [4:0] K_UP    = 5'b00001;
  localparam logic [4:0] K_DOWN  = 5'b00010;
  localparam logic [4:0] K_LEFT  = 5'b00100;
  localparam logic [4:0] K_RIGHT = 5'b01000;
  localparam logic [4:0] K_ENTER = 5'b10000;

  localparam int M_OP1  = 0;
  localparam int M_OP2  = 1;
  localparam int M_DONE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_up, btn_down, btn_left, btn_right, btn_enter;
  logic [2:0]  pos_x;
  logic [1:0]  pos_y;
  logic        mode;
  logic [2:0]  op;
  logic [15:0] op1, op2, input_screen;
  logic        exec_pulse;

  int numChecks = 0;
  int numFails  = 0;
  int execHigh  = 0;
  int execExp   = 0;

  // Keypad model state
  int          mx, my, mop, mstate;
  bit          mmode;
  logic [15:0] mop1, mop2;
  int          mq[$];

  calculator_input_ctrl dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_enter(btn_enter),
    .pos_x(pos_x), .pos_y(pos_y), .mode(mode), .op(op),
    .op1(op1), .op2(op2), .input_screen(input_screen), .exec_pulse(exec_pulse)
  );

  always #5 clk = ~clk;

  // Count every cycle in which the strobe is seen high.
  always @(negedge clk) begin
    if (exec_pulse) execHigh++;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: time limit reached, got no end, expected summary");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] screenValue();
    logic [15:0] v;
    v = 16'h0000;
    foreach (mq[i]) v = {v[11:0], 4'(mq[i])};
    return v;
  endfunction

  function automatic void modelClear();
    mop    = 0;
    mop1   = 16'h0000;
    mop2   = 16'h0000;
    mq.delete();
    mstate = M_OP1;
  endfunction

  function automatic void modelReset();
    mx    = 0;
    my    = 0;
    mmode = 1'b0;
    modelClear();
  endfunction

  function automatic void modelKey(input int x, input int y);
    int d;
    if (x < 4) begin
      d = 4 * y + x;
      if (!mmode && d > 9) return;
      if (mstate == M_DONE) begin
        modelClear();
        mq.push_back(d);
      end else if (mq.size() < 4) begin
        mq.push_back(d);
      end
    end else if (x == 4) begin
      if (mstate == M_OP1) begin
        mop1   = screenValue();
        mop    = y;
        mq.delete();
        mstate = M_OP2;
      end
    end else begin
      case (y)
        0: modelClear();
        1: if (mstate != M_DONE && mq.size() > 0) void'(mq.pop_back());
        2: begin mmode = !mmode; modelClear(); end
        default: if (mstate == M_OP2) begin
          mop2   = screenValue();
          execExp++;
          mstate = M_DONE;
        end
      endcase
    end
  endfunction

  function automatic void modelStep(input logic [4:0] mask);
    int ex, ey;
    ex = mx;
    ey = my;
    if (mask[0])      my = (my + 3) % 4;
    else if (mask[1]) my = (my + 1) % 4;
    else if (mask[2]) mx = (mx + 5) % 6;
    else if (mask[3]) mx = (mx + 1) % 6;
    if (mask[4]) modelKey(ex, ey);
  endfunction

  task automatic checkAll();
    checkOutput("pos_x", pos_x, mx);
    checkOutput("pos_y", pos_y, my);
    checkOutput("mode", mode, mmode);
    checkOutput("op", op, mop);
    checkOutput("op1", op1, mop1);
    checkOutput("op2", op2, mop2);
    checkOutput("input_screen", input_screen, screenValue());
    checkOutput("exec_cycles", execHigh, execExp);
  endtask

  task automatic applyStimulus(input logic [4:0] mask);
    {btn_enter, btn_right, btn_left, btn_down, btn_up} = mask;
    repeat (4) @(posedge clk);
    {btn_enter, btn_right, btn_left, btn_down, btn_up} = 5'b00000;
    repeat (4) @(posedge clk);
    @(negedge clk);
    modelStep(mask);
    checkAll();
  endtask

  task automatic moveTo(input int x, input int y);
    while (mx != x) applyStimulus(K_RIGHT);
    while (my != y) applyStimulus(K_DOWN);
  endtask

  task automatic pressKey(input int x, input int y);
    moveTo(x, y);
    applyStimulus(K_ENTER);
  endtask

  task automatic enterDigit(input int d);
    pressKey(d % 4, d / 4);
  endtask

  initial begin
    int e0;
    bit found;
    logic [4:0] mask;

    rst = 1'b1;
    {btn_enter, btn_right, btn_left, btn_down, btn_up} = 5'b00000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    modelReset();
    checkAll();
    checkOutput("reset_exec", exec_pulse, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Cursor wrap from the origin
    applyStimulus(K_LEFT);
    checkOutput("wrap_left_x", pos_x, 3'd5);
    checkOutput("wrap_left_y", pos_y, 2'd0);
    applyStimulus(K_UP);
    checkOutput("wrap_up_y", pos_y, 2'd3);

    // Decimal filter and four-digit limit
    enterDigit(1); enterDigit(2); enterDigit(10);
    checkOutput("dec_filter", input_screen, 16'h0012);
    enterDigit(3); enterDigit(4); enterDigit(5);
    checkOutput("digit_limit", input_screen, 16'h1234);

    // Full computation
    pressKey(5, 0);
    enterDigit(1); enterDigit(2);
    pressKey(4, 0);
    enterDigit(3); enterDigit(4);
    e0 = execHigh;
    pressKey(5, 3);
    checkOutput("calc_op1", op1, 16'h0012);
    checkOutput("calc_op2", op2, 16'h0034);
    checkOutput("calc_op", op, 3'd0);
    checkOutput("calc_pulse_width", execHigh - e0, 1);

    // Digit after a finished computation starts over
    enterDigit(7);
    checkOutput("done_op1", op1, 16'h0000);
    checkOutput("done_op2", op2, 16'h0000);
    checkOutput("done_screen", input_screen, 16'h0007);

    // Mode toggle clears entry, then hex digits are accepted
    pressKey(5, 0);
    enterDigit(9); enterDigit(9);
    checkOutput("pre_mode_screen", input_screen, 16'h0099);
    pressKey(5, 2);
    checkOutput("mode_hex", mode, 1'b1);
    checkOutput("mode_clear", input_screen, 16'h0000);
    enterDigit(15);
    checkOutput("hex_digit", input_screen, 16'h000F);

    // Enter and right together: old position decoded, move still happens
    pressKey(5, 0);
    moveTo(3, 0);
    applyStimulus(K_ENTER | K_RIGHT);
    checkOutput("combo_screen", input_screen, 16'h0003);
    checkOutput("combo_x", pos_x, 3'd4);

    // Reset in the middle of the strobe
    pressKey(5, 0);
    enterDigit(1);
    pressKey(4, 1);
    enterDigit(2);
    moveTo(5, 3);
    btn_enter = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (exec_pulse) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("exec_seen", found, 1'b1);
    modelStep(K_ENTER);
    #1 rst = 1'b1;
    btn_right = 1'b1;
    #1;
    checkOutput("async_exec", exec_pulse, 1'b0);
    checkOutput("async_pos_x", pos_x, 3'd0);
    checkOutput("async_pos_y", pos_y, 2'd0);
    checkOutput("async_mode", mode, 1'b0);
    checkOutput("async_op", op, 3'd0);
    checkOutput("async_op1", op1, 16'h0000);
    checkOutput("async_op2", op2, 16'h0000);
    checkOutput("async_screen", input_screen, 16'h0000);
    modelReset();
    repeat (3) @(negedge clk);
    btn_enter = 1'b0;
    rst = 1'b0;

    // Button held through reset release must not count as a press
    repeat (10) @(negedge clk);
    checkOutput("held_right", pos_x, 3'd0);
    btn_right = 1'b0;
    repeat (4) @(negedge clk);
    checkAll();
    applyStimulus(K_RIGHT);
    checkOutput("right_after_release", pos_x, 3'd1);

    // Random button traffic against the model
    for (int i = 0; i < 300; i++) begin
      mask = 5'b00000;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) mask[b] = 1'b1;
      if ($urandom_range(0, 1) == 1) mask[4] = 1'b1;
      applyStimulus(mask);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
